// File: rtl/cordic_pkg.sv
// Shared constants for the iterative sin/cos CORDIC: atan table, inverse gain,
// FSM state enum and quadrant codes.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } cordic_state_e;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  // 1/K = 0.607252935... as a 34-bit fraction (units of 2^-34)
  localparam logic [33:0] CORDIC_INV_K = 34'h2_6DD3_B6A1;

  // round(atan(2^-i) / (2*pi) * 2^32): turn fractions at 32-bit resolution
  localparam logic [31:0] ATAN_TABLE [0:31] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

  // 1/K rounded to frac_bits fractional bits
  function automatic logic [63:0] gain_scaled(input int unsigned frac_bits);
    logic [63:0] k;
    k = 64'(CORDIC_INV_K);
    if (frac_bits >= 34) return k << (frac_bits - 34);
    return (k + (64'd1 << (33 - frac_bits))) >> (34 - frac_bits);
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational atan lookup: the 32-bit turn-fraction table scaled to an
// AW-bit binary angle.
module cordic_atan_rom #(
  parameter int AW = 32
) (
  input  logic [4:0]    i,
  output logic [AW-1:0] atan_i
);
  import cordic_pkg::*;

  always_comb begin
    atan_i = AW'(ATAN_TABLE[i] >> (32 - AW));
  end

endmodule

// File: rtl/cordic_sincos_iter.sv
// Iterative rotation-mode CORDIC producing cos/sin of a binary angle, one
// micro-rotation per clock. Define CORDIC_SAT_EN to clamp outputs to +/-1.0 and add sat_o.
module cordic_sincos_iter
  import cordic_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int ITER = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] angle,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] cos_o,
  output logic [DW-1:0] sin_o,
`ifdef CORDIC_SAT_EN
  output logic          sat_o,
`endif
  output logic [1:0]    dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid, once raised, holds with stable data until that edge.
  localparam int XW = DW + 2;
  localparam logic signed [XW-1:0] G_INT = XW'(gain_scaled(DW));
`ifdef CORDIC_SAT_EN
  localparam logic signed [XW-1:0] ONE_R = XW'(64'd1 << (DW - 2));
`endif

  cordic_state_e        state_q;
  logic [4:0]           iter_q;
  logic signed [XW-1:0] x_q, y_q;
  logic signed [AW-1:0] z_q;
  logic                 in_ready_q, out_valid_q;
  logic [DW-1:0]        cos_q, sin_q;
`ifdef CORDIC_SAT_EN
  logic                 sat_q, sat_d;
`endif

  logic signed [XW-1:0] x_st, y_st, x_sh, y_sh, x_d, y_d, x_rnd, y_rnd;
  logic signed [AW-1:0] z_st, z_d;
  logic [AW-1:0]        atan_w;
  logic [DW-1:0]        cos_d, sin_d;
  logic                 last_iter;

  cordic_atan_rom #(.AW(AW)) u_atan (
    .i      (iter_q),
    .atan_i (atan_w)
  );

  assign last_iter = (iter_q == 5'(ITER - 1));

  // Quadrant picks a pre-rotated, gain-compensated start vector so the
  // residual angle handed to the iterations is always in [0, 90 deg).
  always_comb begin
    x_st = '0;
    y_st = '0;
    case (angle[AW-1:AW-2])
      QUAD_0:  x_st = G_INT;
      QUAD_1:  y_st = G_INT;
      QUAD_2:  x_st = -G_INT;
      default: y_st = -G_INT;
    endcase
    z_st = {2'b00, angle[AW-3:0]};
  end

  always_comb begin
    x_sh = x_q >>> iter_q;
    y_sh = y_q >>> iter_q;
    if (!z_q[AW-1]) begin
      x_d = x_q - y_sh;
      y_d = y_q + x_sh;
      z_d = z_q - atan_w;
    end else begin
      x_d = x_q + y_sh;
      y_d = y_q - x_sh;
      z_d = z_q + atan_w;
    end
  end

  // Round half-up by adding 2 before dropping the two guard bits.
  always_comb begin
    x_rnd = (x_d + XW'(2)) >>> 2;
    y_rnd = (y_d + XW'(2)) >>> 2;
    cos_d = DW'(x_rnd);
    sin_d = DW'(y_rnd);
`ifdef CORDIC_SAT_EN
    sat_d = 1'b0;
    if (x_rnd > ONE_R) begin
      cos_d = DW'(ONE_R);
      sat_d = 1'b1;
    end else if (x_rnd < -ONE_R) begin
      cos_d = DW'(-ONE_R);
      sat_d = 1'b1;
    end
    if (y_rnd > ONE_R) begin
      sin_d = DW'(ONE_R);
      sat_d = 1'b1;
    end else if (y_rnd < -ONE_R) begin
      sin_d = DW'(-ONE_R);
      sat_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      iter_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cos_q       <= '0;
      sin_q       <= '0;
`ifdef CORDIC_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            x_q        <= x_st;
            y_q        <= y_st;
            z_q        <= z_st;
            iter_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ROTATE;
          end
        end
        ROTATE: begin
          x_q    <= x_d;
          y_q    <= y_d;
          z_q    <= z_d;
          iter_q <= iter_q + 5'd1;
          if (last_iter) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            cos_q       <= cos_d;
            sin_q       <= sin_d;
`ifdef CORDIC_SAT_EN
            sat_q       <= sat_d;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign cos_o       = cos_q;
  assign sin_o       = sin_q;
  assign dbg_state_o = 2'(state_q);
`ifdef CORDIC_SAT_EN
  assign sat_o       = sat_q;
`endif

endmodule

// File: tb/tb_cordic_sincos_iter.sv
// Self-checking bench for cordic_sincos_iter: timing/handshake model plus a
// real-arithmetic sin/cos reference, directed cases and a random sweep.
module tb_cordic_sincos_iter;

`ifdef CORDIC_SAT_EN
  localparam int DW   = 12;
  localparam int ITER = 8;
`else
  localparam int DW   = 32;
  localparam int ITER = 24;
`endif
  localparam int     AW  = 32;
  localparam longint ONE = longint'(1) << (DW - 2);
  localparam longint TOL = (longint'(1) << (DW - ITER)) + 4;
  localparam real    PI  = 3.14159265358979323846;

  logic          clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [AW-1:0] angle;
  logic [DW-1:0] cos_o, sin_o;
  logic [1:0]    dbg_state;
`ifdef CORDIC_SAT_EN
  logic          sat_o;
`endif

  cordic_sincos_iter #(.DW(DW), .AW(AW), .ITER(ITER)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .angle       (angle),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .cos_o       (cos_o),
    .sin_o       (sin_o),
`ifdef CORDIC_SAT_EN
    .sat_o       (sat_o),
`endif
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    checks_total++;
    if (ok) checks_passed++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  function automatic real rabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  task automatic check_near(input string name, input longint act, input real req);
    check(name, rabs(real'(act) - req) <= real'(TOL), act, longint'(req));
  endtask

  function automatic real model_cos(input logic [AW-1:0] a);
    return $cos(2.0 * PI * real'(a) / (2.0 ** AW)) * real'(ONE);
  endfunction

  function automatic real model_sin(input logic [AW-1:0] a);
    return $sin(2.0 * PI * real'(a) / (2.0 ** AW)) * real'(ONE);
  endfunction

  // scoreboard / behavioural model state
  logic [AW-1:0] exp_q[$];
  bit            model_on = 0;
  bit            ir_exp = 1, ov_exp = 0, busy = 0, zero_exp = 1, first_valid = 0;
  int            cnt = 0;
  logic [AW-1:0] cur_angle;
  real           exp_c, exp_s;
  longint        hold_c, hold_s;

  // model: a result appears ITER edges after acceptance and is held until taken
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      model_on = 1;
      ir_exp = 1; ov_exp = 0; busy = 0; zero_exp = 1; first_valid = 0;
      exp_q.delete();
    end else if (model_on) begin
      if (ir_exp && in_valid) begin
        exp_q.push_back(angle);
        ir_exp = 0; busy = 1; cnt = 0;
      end else if (busy) begin
        cnt++;
        if (cnt == ITER) begin
          busy = 0; ov_exp = 1; first_valid = 1;
          cur_angle = exp_q.pop_front();
          exp_c = model_cos(cur_angle);
          exp_s = model_sin(cur_angle);
        end
      end else if (ov_exp && out_ready) begin
        ov_exp = 0; ir_exp = 1;
      end
    end
  end

  // compare process
  initial forever begin
    longint c, s;
    real rc, rs, nrm;
    @(negedge clk);
    if (model_on) begin
      check("in_ready", in_ready == ir_exp, longint'(in_ready), longint'(ir_exp));
      check("out_valid", out_valid == ov_exp, longint'(out_valid), longint'(ov_exp));
      c = longint'($signed(cos_o));
      s = longint'($signed(sin_o));
      if (ov_exp && first_valid) begin
        first_valid = 0; zero_exp = 0;
        hold_c = c; hold_s = s;
        check_near("cos", c, exp_c);
        check_near("sin", s, exp_s);
        rc = real'(c) / real'(ONE);
        rs = real'(s) / real'(ONE);
        nrm = rc * rc + rs * rs;
        check("norm", rabs(nrm - 1.0) <= 3.0 * real'(TOL) / real'(ONE),
              longint'(nrm * 1.0e6), 1000000);
`ifdef CORDIC_SAT_EN
        check("sat_range", c <= ONE && c >= -ONE && s <= ONE && s >= -ONE, c, ONE);
        if (sat_o)
          check("sat_flag", c == ONE || c == -ONE || s == ONE || s == -ONE, c, ONE);
`endif
      end else if (zero_exp) begin
        check("zero_cos", c == 0, c, 0);
        check("zero_sin", s == 0, s, 0);
      end else begin
        check("hold_cos", c == hold_c, c, hold_c);
        check("hold_sin", s == hold_s, s, hold_s);
      end
    end
  end

  // driver tasks (entered and left just after a falling edge)
  task automatic send(input logic [AW-1:0] a);
    int n = 0;
    in_valid = 1'b1;
    angle    = a;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 1'b0, n, 200);
    @(negedge clk);
    in_valid = 1'b0;
    angle    = AW'($urandom());
  endtask

  task automatic collect(input int hold, output longint c, output longint s);
    int n = 0;
    out_ready = 1'b0;
    while (!out_valid && n < ITER + 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("collect_timeout", 1'b0, n, ITER + 20);
    repeat (hold) @(negedge clk);
    c = longint'($signed(cos_o));
    s = longint'($signed(sin_o));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  function automatic longint lit(input logic [31:0] v);
    return longint'($signed(v)) >>> (32 - DW);
  endfunction

  initial begin
    longint c, s, c0;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; angle = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready == 1'b1, longint'(in_ready), 1);
    check("rst_out_valid", out_valid == 1'b0, longint'(out_valid), 0);
    check("rst_cos", cos_o == '0, longint'(cos_o), 0);
    check("rst_sin", sin_o == '0, longint'(sin_o), 0);
    check("rst_state", dbg_state == 2'(cordic_pkg::IDLE), longint'(dbg_state), 0);
`ifdef CORDIC_SAT_EN
    check("rst_sat", sat_o == 1'b0, longint'(sat_o), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    send(32'h0000_0000);
    collect(0, c, s);
    check_near("a0_cos", c, real'(ONE));
    check_near("a0_sin", s, 0.0);
    check("a0_cos_le_one_tol", c <= ONE + TOL, c, ONE);

    send(32'h2000_0000);
    collect(1, c, s);
    check_near("a45_cos", c, real'(lit(32'h2D41_3CCD)));
    check_near("a45_sin", s, real'(lit(32'h2D41_3CCD)));

    send(32'hC000_0000);
    collect(0, c, s);
    check_near("a270_cos", c, 0.0);
    check_near("a270_sin", s, real'(lit(32'hC000_0000)));

    // backpressure with ignored in_valid pulses in ROTATE and DONE
    send(32'h4000_0000);
    in_valid = 1'b1; angle = 32'h8000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < ITER + 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", out_valid == 1'b1, longint'(out_valid), 1);
    c0 = longint'($signed(sin_o));
    in_valid = 1'b1; angle = 32'h8000_0000;
    repeat (10) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready == 1'b0, longint'(in_ready), 0);
      check("bp_sin_stable", longint'($signed(sin_o)) == c0, longint'($signed(sin_o)), c0);
    end
    in_valid = 1'b0;
    check_near("a90_sin", c0, real'(ONE));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    send(32'h8000_0000);
    collect(2, c, s);
    check_near("a180_cos", c, real'(lit(32'hC000_0000)));
    check_near("a180_sin", s, 0.0);

    // reset in the middle of a rotation
    send(32'h4000_0000);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid == 1'b0, longint'(out_valid), 0);
    check("mid_rst_in_ready", in_ready == 1'b1, longint'(in_ready), 1);
    check("mid_rst_cos", cos_o == '0, longint'(cos_o), 0);
    check("mid_rst_sin", sin_o == '0, longint'(sin_o), 0);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'h1555_5555);
    collect(0, c, s);
    check_near("a30_sin", s, real'(lit(32'h2000_0000)));
    check_near("a30_cos", c, real'(lit(32'h376C_F5D1)));

    // last code before a full turn
    send(32'hFFFF_FFFF);
    collect(0, c, s);
    check_near("amax_cos", c, real'(ONE));
    check_near("amax_sin", s, 0.0);

    for (int k = 0; k < 2000; k++) begin
      send(AW'($urandom()));
      collect($urandom_range(0, 3), c, s);
    end

`ifdef CORDIC_SAT_EN
    send(32'h0000_0000);
    collect(0, c, s);
    check("sat_a0_cos", c <= ONE, c, ONE);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual timeout required finish");
    $display("%0d/%0d checks passed", checks_passed, checks_total + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
